// File: rtl/alu_md_pkg.sv
// Shared definitions for the ALU control decoder and the iterative M-extension sequencer:
// ALU op codes, sequencer states, ALUOp/Funct7/Funct3 constants and decode helpers.
package alu_md_pkg;

  typedef enum logic [3:0] {
    OP_AND  = 4'b0000,
    OP_OR   = 4'b0001,
    OP_ADD  = 4'b0010,
    OP_XOR  = 4'b0011,
    OP_SLL  = 4'b0100,
    OP_SRL  = 4'b0101,
    OP_SUB  = 4'b0110,
    OP_SRA  = 4'b0111,
    OP_BEQ  = 4'b1000,
    OP_BNE  = 4'b1001,
    OP_SLT  = 4'b1010,
    OP_SLTU = 4'b1011,
    OP_BLT  = 4'b1100,
    OP_BGE  = 4'b1101,
    OP_BLTU = 4'b1110,
    OP_BGEU = 4'b1111
  } alu_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_BUSY = 2'b01,
    MD_DONE = 2'b10
  } md_state_e;

  localparam logic [1:0] ALUOP_MEM    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_ARITH  = 2'b10;
  localparam logic [1:0] ALUOP_JUMP   = 2'b11;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  function automatic alu_op_e base_op(input logic [2:0] f3);
    alu_op_e op;
    case (f3)
      3'b000:  op = OP_ADD;
      3'b001:  op = OP_SLL;
      3'b010:  op = OP_SLT;
      3'b011:  op = OP_SLTU;
      3'b100:  op = OP_XOR;
      3'b101:  op = OP_SRL;
      3'b110:  op = OP_OR;
      default: op = OP_AND;
    endcase
    return op;
  endfunction

  // Funct3 010/011 are not branch encodings; they fall back to ADD.
  function automatic alu_op_e branch_op(input logic [2:0] f3);
    alu_op_e op;
    case (f3)
      3'b000:  op = OP_BEQ;
      3'b001:  op = OP_BNE;
      3'b100:  op = OP_BLT;
      3'b101:  op = OP_BGE;
      3'b110:  op = OP_BLTU;
      3'b111:  op = OP_BGEU;
      default: op = OP_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/md_iter_core.sv
// Radix-2 multiply/divide datapath: shared 2*XLEN accumulator (product, or remainder:quotient),
// operand magnitude register, latched sign flags and the final sign correction.
module md_iter_core
  import alu_md_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            step,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic [XLEN-1:0] result
);

  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   m_q, m_d;
  logic [2:0]        f3_q, f3_d;
  logic              neg_lo_q, neg_lo_d;
  logic              neg_hi_q, neg_hi_d;
  logic              div_zero_q, div_zero_d;

  logic              sign_a, sign_b, is_div;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [XLEN:0]     mul_sum, rem_shift;
  logic              rem_ge;
  logic [XLEN-1:0]   rem_new, quo, rem;
  logic [2*XLEN-1:0] acc_mul, acc_div, prod;

  always_comb begin
    is_div = funct3[2];
    sign_a = op_a[XLEN-1] && !(funct3 inside {F3_MULHU, F3_DIVU, F3_REMU});
    sign_b = op_b[XLEN-1] && (funct3 inside {F3_MUL, F3_MULH, F3_DIV, F3_REM});
    mag_a  = sign_a ? -op_a : op_a;
    mag_b  = sign_b ? -op_b : op_b;

    // Multiply: upper half accumulates the multiplicand, lower half shifts the multiplier out.
    mul_sum = acc_q[0] ? ({1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, m_q})
                       : {1'b0, acc_q[2*XLEN-1:XLEN]};
    acc_mul = {mul_sum, acc_q[XLEN-1:1]};

    // Divide: upper half is the partial remainder, lower half shifts dividend out / quotient in.
    rem_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    rem_ge    = rem_shift >= {1'b0, m_q};
    rem_new   = rem_ge ? (rem_shift[XLEN-1:0] - m_q) : rem_shift[XLEN-1:0];
    acc_div   = {rem_new, acc_q[XLEN-2:0], rem_ge};

    acc_d      = acc_q;
    m_d        = m_q;
    f3_d       = f3_q;
    neg_lo_d   = neg_lo_q;
    neg_hi_d   = neg_hi_q;
    div_zero_d = div_zero_q;
    if (start) begin
      acc_d      = {{XLEN{1'b0}}, (is_div ? mag_a : mag_b)};
      m_d        = is_div ? mag_b : mag_a;
      f3_d       = funct3;
      neg_lo_d   = sign_a ^ sign_b;
      neg_hi_d   = sign_a;
      div_zero_d = (op_b == '0);
    end else if (step) begin
      acc_d = f3_q[2] ? acc_div : acc_mul;
    end

    // Result is taken from the post-step value so the top can capture it on entry to DONE.
    prod = neg_lo_q ? -acc_d : acc_d;
    quo  = acc_d[XLEN-1:0];
    rem  = acc_d[2*XLEN-1:XLEN];
    case (f3_q)
      F3_MUL:                        result = prod[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU:  result = prod[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:               result = div_zero_q ? '1 : (neg_lo_q ? -quo : quo);
      default:                       result = neg_hi_q ? -rem : rem;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q      <= '0;
      m_q        <= '0;
      f3_q       <= '0;
      neg_lo_q   <= 1'b0;
      neg_hi_q   <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      m_q        <= m_d;
      f3_q       <= f3_d;
      neg_lo_q   <= neg_lo_d;
      neg_hi_q   <= neg_hi_d;
      div_zero_q <= div_zero_d;
    end
  end

endmodule

// File: rtl/alu_md_controller.sv
// EX-stage ALU control decoder plus iterative M-extension sequencer with stall handshake.
// Optional MD_EARLY_OUT_EN: zero-operand multiplies, divide-by-zero and signed overflow finish in one cycle.
module alu_md_controller
  import alu_md_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      ALUOp,
  input  logic [6:0]      Funct7,
  input  logic [2:0]      Funct3,
  input  logic            ex_valid,
  input  logic            flush,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic [3:0]      Operation,
  output logic            md_sel,
  output logic            md_stall,
  output logic [XLEN-1:0] md_result,
  output logic            md_valid
);

  localparam int CNT_W = $clog2(XLEN + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

  alu_op_e         op;
  md_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] md_result_q, md_result_d, core_result;
  logic            accept, core_start, core_step, stall_raw;

  always_comb begin
    op     = OP_ADD;
    md_sel = 1'b0;
    case (ALUOp)
      ALUOP_BRANCH: op = branch_op(Funct3);
      ALUOP_ARITH: begin
        if (Funct7 == F7_MULDIV)                          md_sel = 1'b1;
        else if (Funct7 == F7_ALT && Funct3 == 3'b000)    op = OP_SUB;
        else if (Funct7 == F7_ALT && Funct3 == 3'b101)    op = OP_SRA;
        else if (Funct7 == F7_BASE || Funct7 == F7_ALT)   op = base_op(Funct3);
      end
      ALUOP_MEM, ALUOP_JUMP: op = OP_ADD;
      default: op = OP_ADD;
    endcase
  end

  assign Operation = op;
  assign accept    = ex_valid && md_sel && !flush;

`ifdef MD_EARLY_OUT_EN
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};
  logic            early_hit;
  logic [XLEN-1:0] early_result;

  // Divide: bit1 selects remainder, bit0 clear means signed.
  always_comb begin
    early_hit    = 1'b0;
    early_result = '0;
    if (Funct3[2]) begin
      if (op_b == '0) begin
        early_hit    = 1'b1;
        early_result = Funct3[1] ? op_a : '1;
      end else if (!Funct3[0] && op_a == MOST_NEG && op_b == '1) begin
        early_hit    = 1'b1;
        early_result = Funct3[1] ? '0 : op_a;
      end
    end else if (op_a == '0 || op_b == '0) begin
      early_hit = 1'b1;
    end
  end
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    md_result_d = md_result_q;
    core_start  = 1'b0;
    core_step   = 1'b0;
    stall_raw   = 1'b0;
    md_valid    = 1'b0;
    if (flush) begin
      state_d = MD_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        MD_IDLE: begin
          if (accept) begin
            core_start = 1'b1;
            stall_raw  = 1'b1;
            cnt_d      = '0;
            state_d    = MD_BUSY;
`ifdef MD_EARLY_OUT_EN
            if (early_hit) begin
              state_d     = MD_DONE;
              md_result_d = early_result;
            end
`endif
          end
        end
        MD_BUSY: begin
          stall_raw = 1'b1;
          core_step = 1'b1;
          cnt_d     = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_d     = MD_DONE;
            cnt_d       = '0;
            md_result_d = core_result;
          end
        end
        MD_DONE: begin
          md_valid = 1'b1;
          state_d  = MD_IDLE;
        end
        default: state_d = MD_IDLE;
      endcase
    end
    // Reset must silence the stall even while an M op is sitting in EX.
    md_stall = stall_raw && rst_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= MD_IDLE;
      cnt_q       <= '0;
      md_result_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      md_result_q <= md_result_d;
    end
  end

  assign md_result = md_result_q;

  md_iter_core #(.XLEN(XLEN)) u_core (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (core_start),
    .step   (core_step),
    .funct3 (Funct3),
    .op_a   (op_a),
    .op_b   (op_b),
    .result (core_result)
  );

endmodule

// File: tb/tb_alu_md_controller.sv
// Self-checking bench for alu_md_controller: per-cycle reference model plus directed M-op vectors.
module tb_alu_md_controller;

  localparam int XLEN = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  ALUOp = '0;
  logic [6:0]  Funct7 = '0;
  logic [2:0]  Funct3 = '0;
  logic        ex_valid = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic [3:0]  Operation;
  logic        md_sel, md_stall, md_valid;
  logic [31:0] md_result;

  int n_checks = 0;
  int n_fail = 0;

  int          m_k = 0;
  logic [31:0] m_pend = '0;
  logic [31:0] m_last = '0;

  localparam logic [3:0] BASE_TBL [8] = '{4'b0010, 4'b0100, 4'b1010, 4'b1011,
                                          4'b0011, 4'b0101, 4'b0001, 4'b0000};
  localparam logic [3:0] BR_TBL [8]   = '{4'b1000, 4'b1001, 4'b0010, 4'b0010,
                                          4'b1100, 4'b1101, 4'b1110, 4'b1111};
  localparam logic [6:0] F7_LIST [5]  = '{7'h00, 7'h20, 7'h01, 7'h7f, 7'h30};

  always #5 clk = ~clk;

  alu_md_controller #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ALUOp     (ALUOp),
    .Funct7    (Funct7),
    .Funct3    (Funct3),
    .ex_valid  (ex_valid),
    .flush     (flush),
    .op_a      (op_a),
    .op_b      (op_b),
    .Operation (Operation),
    .md_sel    (md_sel),
    .md_stall  (md_stall),
    .md_result (md_result),
    .md_valid  (md_valid)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [3:0] dec_model(input logic [1:0] aop, input logic [6:0] f7,
                                           input logic [2:0] f3);
    if (aop == 2'b01) return BR_TBL[f3];
    if (aop != 2'b10) return 4'b0010;
    if (f7 == 7'h20 && f3 == 3'd0) return 4'b0110;
    if (f7 == 7'h20 && f3 == 3'd5) return 4'b0111;
    if (f7 == 7'h00 || f7 == 7'h20) return BASE_TBL[f3];
    return 4'b0010;
  endfunction

  function automatic logic [31:0] md_model(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] b);
    longint      sp;
    logic [63:0] up;
    int          sa, sb;
    sa = a;
    sb = b;
    up = {32'd0, a} * {32'd0, b};
    sp = longint'(sa) * longint'(sb);
    case (f3)
      3'd0: return up[31:0];
      3'd1: return sp[63:32];
      3'd2: begin
        sp = longint'(sa) * longint'({32'd0, b});
        return sp[63:32];
      end
      3'd3: return up[63:32];
      3'd4: begin
        if (b == 32'd0) return 32'hffffffff;
        if (a == 32'h80000000 && b == 32'hffffffff) return a;
        return 32'(sa / sb);
      end
      3'd5: return (b == 32'd0) ? 32'hffffffff : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h80000000 && b == 32'hffffffff) return 32'd0;
        return 32'(sa % sb);
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  function automatic bit early_case(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
`ifdef MD_EARLY_OUT_EN
    if (f3[2]) return (b == 32'd0) || (!f3[0] && a == 32'h80000000 && b == 32'hffffffff);
    return (a == 32'd0) || (b == 32'd0);
`else
    return (f3 == 3'd0) && (a == 32'd0) && (b == 32'd0) && 1'b0;
`endif
  endfunction

  // Model: m_k = 0 idle, else cycles since the accepting cycle; XLEN+1 is the result cycle.
  always @(negedge clk) begin
    logic       req, exp_sel, exp_stall, exp_valid;
    logic [3:0] exp_op;
    exp_op  = dec_model(ALUOp, Funct7, Funct3);
    exp_sel = (ALUOp == 2'b10) && (Funct7 == 7'h01);
    check("operation", 64'(Operation), 64'(exp_op));
    check("md_sel", 64'(md_sel), 64'(exp_sel));
    req = ex_valid && exp_sel && !flush;
    if (!rst_n) begin
      exp_stall = 1'b0;
      exp_valid = 1'b0;
      m_k       = 0;
      m_last    = '0;
    end else if (m_k == 0) begin
      exp_stall = req;
      exp_valid = 1'b0;
    end else if (m_k <= XLEN) begin
      exp_stall = !flush;
      exp_valid = 1'b0;
    end else begin
      exp_stall = 1'b0;
      exp_valid = !flush;
    end
    check("md_stall", 64'(md_stall), 64'(exp_stall));
    check("md_valid", 64'(md_valid), 64'(exp_valid));
    check("md_result", 64'(md_result), 64'(m_last));
    if (rst_n) begin
      if (flush) begin
        m_k = 0;
      end else if (m_k == 0) begin
        if (req) begin
          m_pend = md_model(Funct3, op_a, op_b);
          if (early_case(Funct3, op_a, op_b)) begin
            m_k    = XLEN + 1;
            m_last = m_pend;
          end else begin
            m_k = 1;
          end
        end
      end else if (m_k < XLEN) begin
        m_k++;
      end else if (m_k == XLEN) begin
        m_k    = XLEN + 1;
        m_last = m_pend;
      end else begin
        m_k = 0;
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Issues one M op, waits for md_valid, then retires it; entered and left at posedge+1.
  task automatic do_md(input string nm, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] lit);
    int lat, stalls, exp_lat;
    bit got;
    check({nm, "_model"}, 64'(md_model(f3, a, b)), 64'(lit));
    exp_lat  = early_case(f3, a, b) ? 1 : XLEN + 1;
    ALUOp    = 2'b10;
    Funct7   = 7'h01;
    Funct3   = f3;
    op_a     = a;
    op_b     = b;
    ex_valid = 1'b1;
    lat      = 0;
    stalls   = 0;
    got      = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (md_stall) stalls++;
      if (md_valid) begin
        got = 1'b1;
        check({nm, "_result"}, 64'(md_result), 64'(lit));
      end else begin
        lat++;
        next_cycle();
      end
    end
    check({nm, "_done"}, 64'(got), 64'(1));
    check({nm, "_latency"}, 64'(lat), 64'(exp_lat));
    check({nm, "_stall_cycles"}, 64'(stalls), 64'(exp_lat));
    $display("op %s f3=%0d a=%h b=%h -> %h after %0d cycles", nm, f3, a, b, md_result, lat);
    next_cycle();
    ex_valid = 1'b0;
  endtask

  initial begin
    int vcount;
    rst_n = 1'b0;
    next_cycle();
    check("reset_stall", 64'(md_stall), 64'(0));
    check("reset_valid", 64'(md_valid), 64'(0));
    check("reset_result", 64'(md_result), 64'(0));
    next_cycle();
    rst_n = 1'b1;
    next_cycle();

    for (int o = 0; o < 4; o++)
      for (int j = 0; j < 5; j++)
        for (int f = 0; f < 8; f++) begin
          ALUOp  = 2'(o);
          Funct7 = F7_LIST[j];
          Funct3 = 3'(f);
          next_cycle();
        end
    $display("decode sweep: 160 combinations");

    ALUOp = 2'b10; Funct7 = 7'h20; Funct3 = 3'd5; #1;
    check("dec_sra_lit", 64'(Operation), 64'(4'b0111));
    check("dec_sra_model", 64'(dec_model(ALUOp, Funct7, Funct3)), 64'(4'b0111));
    ALUOp = 2'b01; Funct7 = 7'h00; Funct3 = 3'd6; #1;
    check("dec_bltu_lit", 64'(Operation), 64'(4'b1110));
    ALUOp = 2'b10; Funct7 = 7'h00; Funct3 = 3'd2; #1;
    check("dec_slt_lit", 64'(Operation), 64'(4'b1010));
    ALUOp = 2'b11; Funct7 = 7'h20; Funct3 = 3'd0; #1;
    check("dec_jal_lit", 64'(Operation), 64'(4'b0010));
    next_cycle();

    do_md("mul",    3'd0, 32'hffffffff, 32'h2,        32'hfffffffe);
    do_md("mulhu",  3'd3, 32'hffffffff, 32'h2,        32'h00000001);
    do_md("mulh",   3'd1, 32'h80000000, 32'h80000000, 32'h40000000);
    do_md("mulhsu", 3'd2, 32'hffffffff, 32'hffffffff, 32'hffffffff);
    do_md("mul0",   3'd0, 32'h0,        32'h5,        32'h0);
    do_md("div",    3'd4, 32'hfffffff9, 32'h2,        32'hfffffffd);
    do_md("rem",    3'd6, 32'hfffffff9, 32'h2,        32'hffffffff);
    do_md("divu",   3'd5, 32'h7,        32'h2,        32'h3);
    do_md("divneg", 3'd4, 32'h7,        32'hfffffffe, 32'hfffffffd);
    do_md("remneg", 3'd6, 32'h7,        32'hfffffffe, 32'h1);
    do_md("remu",   3'd7, 32'd100,      32'd7,        32'd2);
    do_md("div0",   3'd4, 32'h1234,     32'h0,        32'hffffffff);
    do_md("rem0",   3'd6, 32'h1234,     32'h0,        32'h1234);
    do_md("remn0",  3'd6, 32'hfffffff9, 32'h0,        32'hfffffff9);
    do_md("divu0",  3'd5, 32'h80000000, 32'h0,        32'hffffffff);
    do_md("remu0",  3'd7, 32'h5,        32'h0,        32'h5);
    do_md("divovf", 3'd4, 32'h80000000, 32'hffffffff, 32'h80000000);
    do_md("removf", 3'd6, 32'h80000000, 32'hffffffff, 32'h0);

    ALUOp = 2'b10; Funct7 = 7'h01; Funct3 = 3'd0; op_a = 32'd3; op_b = 32'd5; ex_valid = 1'b1;
    repeat (10) next_cycle();
    flush = 1'b1;
    @(negedge clk);
    check("flush_stall", 64'(md_stall), 64'(0));
    check("flush_valid", 64'(md_valid), 64'(0));
    next_cycle();
    flush = 1'b0;
    ex_valid = 1'b0;
    vcount = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (md_valid || md_stall) vcount++;
      next_cycle();
    end
    check("flush_quiet", 64'(vcount), 64'(0));
    $display("flush at busy cycle 10: %0d activity cycles afterwards", vcount);
    do_md("mulh_post_flush", 3'd1, 32'h40000000, 32'h4, 32'h1);
    do_md("mulh_neg",        3'd1, 32'hfffffffe, 32'h3, 32'hffffffff);

    ALUOp = 2'b10; Funct7 = 7'h01; Funct3 = 3'd3; op_a = 32'hffffffff; op_b = 32'hffffffff;
    ex_valid = 1'b1;
    repeat (5) next_cycle();
    #2 rst_n = 1'b0;
    #1;
    check("areset_stall", 64'(md_stall), 64'(0));
    check("areset_valid", 64'(md_valid), 64'(0));
    check("areset_result", 64'(md_result), 64'(0));
    $display("async reset mid-busy: stall=%b valid=%b result=%h", md_stall, md_valid, md_result);
    ex_valid = 1'b0;
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
    do_md("mul_after_rst",  3'd0, 32'd7,   32'd6, 32'd42);
    do_md("divu_after_rst", 3'd5, 32'd100, 32'd7, 32'd14);

    repeat (3) next_cycle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
